// File: rtl/da_add_tree.sv
// Pipelined unsigned adder tree reducing LANES packed lanes to one sum, one register per level.
// Optional saturation of the final sum to OSIZE bits is enabled by defining DA_SAT_EN.
module da_add_tree #(
  parameter int DSIZE = 11,
  parameter int LANES = 5,
  parameter int OSIZE = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   vld_i,
  input  logic [DSIZE*LANES-1:0] idata,
  output logic                   vld_o,
  output logic [OSIZE-1:0]       odata,
  output logic                   ovf_o
);

  localparam int S  = (LANES <= 1) ? 1 : $clog2(LANES);
  localparam int FW = DSIZE + S;
`ifdef DA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  // When wrapping into a narrower output, the last level only needs OSIZE bits.
  localparam bit TRUNC = !SAT && (OSIZE < FW);
  localparam int LW    = TRUNC ? OSIZE : FW;

  function automatic int lanes_at(input int lvl);
    int n;
    n = LANES;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  for (genvar j = 1; j <= S; j++) begin : g_lvl
    localparam int NI = lanes_at(j - 1);
    localparam int NO = lanes_at(j);
    localparam int WI = DSIZE + j - 1;
    localparam int WO = (j == S) ? LW : DSIZE + j;

    logic [NI*WI-1:0] d;
    logic [NO*WO-1:0] sum;

    if (j == 1) begin : g_in
      assign d = idata;
    end else begin : g_link
      assign d = g_lvl[j-1].g_reg.q;
    end

    for (genvar m = 0; m < NO; m++) begin : g_lane
      if (2 * m + 1 < NI) begin : g_add
        assign sum[m*WO +: WO] = WO'(d[2*m*WI +: WI]) + WO'(d[(2*m+1)*WI +: WI]);
      end else begin : g_pass
        assign sum[m*WO +: WO] = WO'(d[2*m*WI +: WI]);
      end
    end

    // The last level's sum feeds the output register directly.
    if (j < S) begin : g_reg
      logic [NO*WO-1:0] q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (ce) q <= sum;
      end
    end
  end

  logic [LW-1:0]    fsum;
  logic [OSIZE-1:0] map_data;
  logic             map_ovf;

  assign fsum = g_lvl[S].sum;

  if (OSIZE >= FW) begin : g_ext
    assign map_data = OSIZE'(fsum);
    assign map_ovf  = 1'b0;
`ifdef DA_SAT_EN
  end else begin : g_sat
    assign map_ovf  = |fsum[FW-1:OSIZE];
    assign map_data = map_ovf ? {OSIZE{1'b1}} : fsum[OSIZE-1:0];
`else
  end else begin : g_wrap
    assign map_data = fsum;
    assign map_ovf  = 1'b0;
`endif
  end

  logic [S-1:0] vld_pipe;

  // Valid flag travels in lockstep with the data levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (ce) begin
      vld_pipe[0] <= vld_i;
      for (int i = 1; i < S; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign vld_o = vld_pipe[S-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odata <= '0;
      ovf_o <= 1'b0;
    end else if (ce) begin
      odata <= map_data;
      ovf_o <= map_ovf;
    end
  end

endmodule

// File: tb/tb_da_add_tree.sv
// Directed self-checking bench for da_add_tree: default 5-lane tree plus OSIZE=13,
// LANES=1 and LANES=4 instances sharing clock, reset, ce and vld_i.
module tb_da_add_tree;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        vld_i = 1'b0;
  logic [54:0] idata = '0;
  logic [10:0] idata1 = '0;
  logic [43:0] idata4 = '0;

  logic        d_vld, o_vld, l1_vld, l4_vld;
  logic        d_ovf, o_ovf, l1_ovf, l4_ovf;
  logic [13:0] d_data;
  logic [12:0] o_data;
  logic [11:0] l1_data;
  logic [12:0] l4_data;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DA_SAT_EN
  localparam int EXP13_DATA = 8191;
  localparam int EXP13_OVF  = 1;
`else
  localparam int EXP13_DATA = 2043;
  localparam int EXP13_OVF  = 0;
`endif

  da_add_tree #(.DSIZE(11), .LANES(5), .OSIZE(14)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .vld_i(vld_i), .idata(idata),
    .vld_o(d_vld), .odata(d_data), .ovf_o(d_ovf));

  da_add_tree #(.DSIZE(11), .LANES(5), .OSIZE(13)) u_o13 (
    .clk(clk), .rst(rst), .ce(ce), .vld_i(vld_i), .idata(idata),
    .vld_o(o_vld), .odata(o_data), .ovf_o(o_ovf));

  da_add_tree #(.DSIZE(11), .LANES(1), .OSIZE(12)) u_l1 (
    .clk(clk), .rst(rst), .ce(ce), .vld_i(vld_i), .idata(idata1),
    .vld_o(l1_vld), .odata(l1_data), .ovf_o(l1_ovf));

  da_add_tree #(.DSIZE(11), .LANES(4), .OSIZE(13)) u_l4 (
    .clk(clk), .rst(rst), .ce(ce), .vld_i(vld_i), .idata(idata4),
    .vld_o(l4_vld), .odata(l4_data), .ovf_o(l4_ovf));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [54:0] pack5(input logic [10:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [54:0] all5(input logic [10:0] v);
    return {v, v, v, v, v};
  endfunction

  // Drive inputs, take one clock edge, leave time 1 unit past the edge for sampling.
  task automatic step(input logic v, input logic [54:0] d, input logic c);
    vld_i = v;
    idata = d;
    ce    = c;
    @(posedge clk);
    #1;
  endtask

  int   st_data [0:12] = '{0, 0, 0, 5, 5, 5, 10, 15, 20, 25, 30, 35, 0};
  logic st_vld  [0:12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // 1. reset and latency: inputs active during reset must be ignored
    vld_i = 1'b1;
    idata = all5(11'd9);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_vld", 32'(d_vld), 32'd0);
      chk("rst_data", 32'(d_data), 32'd0);
      chk("rst_ovf", 32'(d_ovf), 32'd0);
    end
    vld_i = 1'b0;
    rst   = 1'b0;
    step(1'b1, pack5(11'd1, 11'd2, 11'd3, 11'd4, 11'd5), 1'b1);
    chk("lat_vld_c1", 32'(d_vld), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("lat_vld_c2", 32'(d_vld), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("lat_vld_c3", 32'(d_vld), 32'd1);
    chk("lat_data", 32'(d_data), 32'd15);
    chk("lat_o13_data", 32'(o_data), 32'd15);
    step(1'b0, '0, 1'b1);
    chk("lat_vld_after", 32'(d_vld), 32'd0);

    // 2. streaming: lanes all k, k=0..7 back to back
    for (int t = 0; t <= 10; t++) begin
      step(t < 8, all5(11'(t)), 1'b1);
      chk("str_vld", 32'(d_vld), (t >= 2 && t < 10) ? 32'd1 : 32'd0);
      if (t >= 2 && t < 10) chk("str_data", 32'(d_data), 32'(5 * (t - 2)));
    end

    // 3. same stream with a two-cycle stall; stalled inputs carry junk
    begin
      int k;
      k = 0;
      for (int t = 0; t <= 12; t++) begin
        if (t == 4 || t == 5) begin
          step(1'b1, all5(11'd99), 1'b0);
        end else begin
          step(k < 8, all5(11'(k)), 1'b1);
          k++;
        end
        chk("stl_vld", 32'(d_vld), 32'(st_vld[t]));
        if (st_vld[t]) chk("stl_data", 32'(d_data), 32'(st_data[t]));
      end
    end

    // 4. maximum input: full sum 10235
    step(1'b1, all5(11'd2047), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("max_vld", 32'(d_vld), 32'd1);
    chk("max_data14", 32'(d_data), 32'd10235);
    chk("max_ovf14", 32'(d_ovf), 32'd0);
    chk("max_vld13", 32'(o_vld), 32'd1);
    chk("max_data13", 32'(o_data), 32'(EXP13_DATA));
    chk("max_ovf13", 32'(o_ovf), 32'(EXP13_OVF));
    step(1'b0, '0, 1'b1);
    chk("max_ovf13_clr", 32'(o_ovf), 32'd0);

    // 5. reset while samples are in flight
    step(1'b1, all5(11'd10), 1'b1);
    step(1'b1, all5(11'd20), 1'b1);
    step(1'b1, all5(11'd30), 1'b1);
    chk("inf_vld_pre", 32'(d_vld), 32'd1);
    chk("inf_data_pre", 32'(d_data), 32'd50);
    rst = 1'b1;
    #2;
    chk("inf_vld_async", 32'(d_vld), 32'd0);
    chk("inf_data_async", 32'(d_data), 32'd0);
    vld_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step(1'b0, '0, 1'b1);
      chk("inf_no_stale", 32'(d_vld), 32'd0);
    end

    // 6. edge lane counts: LANES=1 and LANES=4
    idata1 = 11'd7;
    idata4 = {11'd400, 11'd300, 11'd200, 11'd100};
    step(1'b1, '0, 1'b1);
    chk("l1_vld", 32'(l1_vld), 32'd1);
    chk("l1_data", 32'(l1_data), 32'd7);
    chk("l4_vld_c1", 32'(l4_vld), 32'd0);
    idata1 = '0;
    idata4 = '0;
    step(1'b0, '0, 1'b1);
    chk("l1_vld_after", 32'(l1_vld), 32'd0);
    chk("l4_vld", 32'(l4_vld), 32'd1);
    chk("l4_data", 32'(l4_data), 32'd1000);
    chk("l4_ovf", 32'(l4_ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
